// File: rtl/vc_arbiter_if.sv
// Purpose: interface bundle between the VC FIFOs / destination FIFOs and the VC arbiter.
// Signals: enable, VC0/VC1 empty flags and head words, D0/D1 almost-full flags (into the arbiter);
//          VC0/VC1 pop strobes, valid_out, vc_sel, state_out (out of the arbiter).
// Modports: slave = arbiter side, master = environment side.
interface vc_arbiter_if #(
  parameter int unsigned BW = 6
);
  logic          enable;
  logic          VC0_empty;
  logic          VC1_empty;
  logic [BW-1:0] VC0_head;
  logic [BW-1:0] VC1_head;
  logic          D0_almost_full;
  logic          D1_almost_full;
  logic          VC0_pop;
  logic          VC1_pop;
  logic          valid_out;
  logic          vc_sel;
  logic [1:0]    state_out;

  modport slave (
    input  enable, VC0_empty, VC1_empty, VC0_head, VC1_head,
           D0_almost_full, D1_almost_full,
    output VC0_pop, VC1_pop, valid_out, vc_sel, state_out
  );

  modport master (
    output enable, VC0_empty, VC1_empty, VC0_head, VC1_head,
           D0_almost_full, D1_almost_full,
    input  VC0_pop, VC1_pop, valid_out, vc_sel, state_out
  );
endinterface

// File: rtl/vc_arbiter.sv
// Purpose: weighted two-VC arbiter. VC0 may take up to WEIGHT consecutive grants while
//          VC1 is eligible, then VC1 gets one. A VC is eligible only when enabled, non-empty
//          and the destination selected by its head word is not almost full.
// Ports:   clk, reset_L (async active-low), bus (vc_arbiter_if.slave):
//          VC0_pop/VC1_pop combinational; valid_out, vc_sel, state_out registered.
module vc_arbiter #(
  parameter int unsigned BW       = 6,
  parameter int unsigned WEIGHT   = 4,
  parameter int unsigned DEST_BIT = 4
) (
  input  logic         clk,
  input  logic         reset_L,
  vc_arbiter_if.slave  bus
);

  localparam int unsigned CW       = 4;
  localparam int unsigned DEST_IDX = (DEST_BIT < BW) ? DEST_BIT : BW - 1;
  localparam logic [CW-1:0] WMAX   = CW'(WEIGHT);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    S_VC0 = 2'b01,
    S_VC1 = 2'b10
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          e0, e1;
  logic          g0, g1;

  // Eligibility, grant selection, counter update and pop strobes.
  always_comb begin
    state_nxt   = IDLE;
    cnt_nxt     = cnt;
    g0          = 1'b0;
    g1          = 1'b0;
    e0 = bus.enable & ~bus.VC0_empty &
         ~(bus.VC0_head[DEST_IDX] ? bus.D1_almost_full : bus.D0_almost_full);
    e1 = bus.enable & ~bus.VC1_empty &
         ~(bus.VC1_head[DEST_IDX] ? bus.D1_almost_full : bus.D0_almost_full);

    if (e0 && ((cnt < WMAX) || !e1)) begin
      g0        = 1'b1;
      state_nxt = S_VC0;
      cnt_nxt   = (cnt < WMAX) ? cnt + CW'(1) : WMAX;
    end else if (e1) begin
      g1        = 1'b1;
      state_nxt = S_VC1;
      cnt_nxt   = '0;
    end

    // Reset masks the strobes asynchronously so nothing is popped while held in reset.
    bus.VC0_pop = g0 & reset_L;
    bus.VC1_pop = g1 & reset_L;
  end

  // State, counter and the one-cycle-delayed grant report.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.valid_out <= 1'b0;
      bus.vc_sel    <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      bus.valid_out <= g0 | g1;
      if (g0 | g1) begin
        bus.vc_sel <= g1;
      end
    end
  end

  assign bus.state_out = state;

endmodule

// File: tb/tb_vc_arbiter.sv
// Purpose: directed self-checking bench for vc_arbiter (BW=6, WEIGHT=4, DEST_BIT=4).
// Pop strobes are checked against each step's directed expectation; the registered
// valid_out/vc_sel/state_out expectations are queued and compared one cycle later.
module tb_vc_arbiter;

  typedef struct packed {
    logic       valid;
    logic       sel;
    logic [1:0] state;
  } exp_t;

  logic clk;
  logic reset_L;
  int   n_cmp;
  int   n_fail;
  logic last_sel;
  exp_t sb[$];

  vc_arbiter_if #(.BW(6)) bus ();

  vc_arbiter #(.BW(6), .WEIGHT(4), .DEST_BIT(4)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_reset();
    sb.delete();
    sb.push_back(exp_t'(4'b0000));
    last_sel = 1'b0;
  endtask

  // One clock cycle: check strobes at the falling edge, retire the queued registered
  // expectation, queue the one produced by this cycle's grant, advance past the rising edge.
  task automatic step(input logic p0, input logic p1, input string tag);
    exp_t e;
    exp_t n;
    @(negedge clk);
    check({tag, ":VC0_pop"}, {3'b000, bus.VC0_pop}, {3'b000, p0});
    check({tag, ":VC1_pop"}, {3'b000, bus.VC1_pop}, {3'b000, p1});
    check({tag, ":sb_nonempty"}, {3'b000, sb.size() > 0}, 4'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, ":valid_out"}, {3'b000, bus.valid_out}, {3'b000, e.valid});
      check({tag, ":vc_sel"},    {3'b000, bus.vc_sel},    {3'b000, e.sel});
      check({tag, ":state_out"}, {2'b00, bus.state_out},  {2'b00, e.state});
    end
    n.valid  = p0 | p1;
    n.sel    = p1 ? 1'b1 : (p0 ? 1'b0 : last_sel);
    n.state  = p0 ? 2'b01 : (p1 ? 2'b10 : 2'b00);
    last_sel = n.sel;
    sb.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ":VC0_pop"},   {3'b000, bus.VC0_pop},   4'd0);
    check({tag, ":VC1_pop"},   {3'b000, bus.VC1_pop},   4'd0);
    check({tag, ":valid_out"}, {3'b000, bus.valid_out}, 4'd0);
    check({tag, ":vc_sel"},    {3'b000, bus.vc_sel},    4'd0);
    check({tag, ":state_out"}, {2'b00, bus.state_out},  4'd0);
  endtask

  initial begin
    n_cmp              = 0;
    n_fail             = 0;
    last_sel           = 1'b0;
    reset_L            = 1'b1;
    bus.enable         = 1'b1;
    bus.VC0_empty      = 1'b0;
    bus.VC1_empty      = 1'b0;
    bus.VC0_head       = 6'h00;
    bus.VC1_head       = 6'h00;
    bus.D0_almost_full = 1'b0;
    bus.D1_almost_full = 1'b0;

    // Reset with both VCs non-empty and enabled: everything quiet, also across an edge.
    #2 reset_L = 1'b0;
    #1 check_reset_outputs("rst_async");
    @(posedge clk);
    #1 check_reset_outputs("rst_held");
    reset_L = 1'b1;
    sb_reset();

    // Both VCs always eligible: 4 x VC0 then 1 x VC1, repeating.
    repeat (2) begin
      repeat (4) step(1'b1, 1'b0, "rr_vc0");
      step(1'b0, 1'b1, "rr_vc1");
    end

    // VC1 alone, 8 words, then drained.
    bus.VC0_empty = 1'b1;
    repeat (8) step(1'b0, 1'b1, "vc1_only");
    bus.VC1_empty = 1'b1;
    repeat (2) step(1'b0, 1'b0, "vc1_drained");

    // VC0 targets D1 which is almost full: only VC1 proceeds; releasing D1 resumes VC0.
    bus.VC0_empty      = 1'b0;
    bus.VC1_empty      = 1'b0;
    bus.VC0_head       = 6'h10;
    bus.VC1_head       = 6'h00;
    bus.D1_almost_full = 1'b1;
    repeat (4) step(1'b0, 1'b1, "af_block");
    bus.D1_almost_full = 1'b0;
    repeat (4) step(1'b1, 1'b0, "af_resume");
    step(1'b0, 1'b1, "af_rr_vc1");

    // Enable drops right after a VC0 pop: that pop still reports, then idle.
    bus.VC1_empty = 1'b1;
    step(1'b1, 1'b0, "en_pop");
    bus.enable = 1'b0;
    step(1'b0, 1'b0, "en_drop");
    step(1'b0, 1'b0, "en_idle");

    // Build cnt = 2 mid-burst, then pulse reset between edges.
    bus.enable    = 1'b1;
    bus.VC0_empty = 1'b1;
    bus.VC1_empty = 1'b0;
    bus.VC0_head  = 6'h00;
    step(1'b0, 1'b1, "pre_vc1");
    bus.VC0_empty = 1'b0;
    repeat (2) step(1'b1, 1'b0, "pre_vc0");
    #1 reset_L = 1'b0;
    #1 check_reset_outputs("rst_mid");
    #1 reset_L = 1'b1;
    sb_reset();
    repeat (4) step(1'b1, 1'b0, "post_rst_vc0");
    step(1'b0, 1'b1, "post_rst_vc1");
    bus.enable = 1'b0;
    step(1'b0, 1'b0, "tail");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vc_arbiter.md
VC_ARBITER -- requirements
Module: vc_arbiter

Interface
REQ-001 Parameter BW, default 6: word width of the VC FIFO head data.
REQ-002 Parameter WEIGHT, default 4: maximum consecutive VC0 grants while VC1 is waiting; legal range 1..15.
REQ-003 Parameter DEST_BIT, default 4: bit index of the head word that selects the destination (0 = D0, 1 = D1).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset_L  input  1  asynchronous active-low reset.
REQ-006 enable  input  1  arbitration enable, driven by the conditioning FSM active state.
REQ-007 VC0_empty  input  1  VC0 FIFO empty flag.
REQ-008 VC1_empty  input  1  VC1 FIFO empty flag.
REQ-009 VC0_head  input  BW  VC0 FIFO head word (first-word-fall-through view).
REQ-010 VC1_head  input  BW  VC1 FIFO head word.
REQ-011 D0_almost_full  input  1  D0 FIFO almost-full flag.
REQ-012 D1_almost_full  input  1  D1 FIFO almost-full flag.
REQ-013 VC0_pop  output  1  combinational pop strobe to VC0.
REQ-014 VC1_pop  output  1  combinational pop strobe to VC1.
REQ-015 valid_out  output  1  registered; data from the previous cycle's pop is present at the mux output.
REQ-016 vc_sel  output  1  registered mux select (0 = VC0, 1 = VC1) matching valid_out.
REQ-017 state_out  output  2  current FSM state: 00 IDLE, 01 S_VC0, 10 S_VC1.

Function
REQ-018 Eligibility SHALL be computed as follows.
- E0 = enable & !VC0_empty & !Dn_almost_full, where n = VC0_head[DEST_BIT].
- E1 is the same for VC1, using VC1_head.
REQ-019 Grant rules SHALL be applied each cycle, and at most one pop SHALL be asserted per cycle.
- Grant VC0 if E0 & (cnt < WEIGHT | !E1).
- Otherwise grant VC1 if E1.
- Otherwise grant none.
REQ-020 cnt SHALL be a 4-bit consecutive-VC0 counter.
- VC0 grant: cnt = min(cnt+1, WEIGHT).
- VC1 grant: cnt = 0.
- No grant: cnt holds.
REQ-021 FSM next state SHALL be S_VC0 on a VC0 grant, S_VC1 on a VC1 grant, and IDLE on no grant; every state reaches every state.
REQ-022 valid_out and vc_sel SHALL register the grant with 1-cycle latency.
- valid_out(t+1) = VC0_pop(t) | VC1_pop(t).
- vc_sel(t+1) = VC1_pop(t).
- vc_sel holds its value when there is no grant.
REQ-023 An E1 stream alone SHALL pop VC1 every cycle, and an E0 stream alone SHALL pop VC0 every cycle, with cnt saturating at WEIGHT.
REQ-024 With E0 and E1 both continuously true, the grant sequence SHALL be WEIGHT VC0 pops, then 1 VC1 pop, repeating.
REQ-025 Almost-full on a destination SHALL block only the VC whose head targets it; the other VC SHALL proceed.
REQ-026 When enable deasserts, pops SHALL stop in the same cycle, and a pop issued in the prior cycle SHALL still produce valid_out.
REQ-027 Pops SHALL never be asserted on an empty VC, including when empty and the grant condition change in the same cycle.

Reset
REQ-028 While reset_L = 0, the block SHALL immediately and asynchronously hold the following values.
- state = IDLE, cnt = 0, valid_out = 0, vc_sel = 0.
- VC0_pop = VC1_pop = 0, regardless of the other inputs.
REQ-029 Reset asserted mid-burst SHALL discard cnt, and arbitration SHALL restart from cnt = 0 on the first edge after release.

Verification
REQ-030 The bench SHALL cover the following directed scenarios.
- Reset: reset_L = 0 with both VCs non-empty -> pops 0, valid_out 0, state_out 00.
- Both VCs full, no almost-full, WEIGHT = 4 -> pop pattern VC0,VC0,VC0,VC0,VC1 repeating; vc_sel follows one cycle later.
- VC1 only, 8 words -> VC1_pop for 8 consecutive cycles, then 0; valid_out high on cycles 2..9; cnt stays 0.
- VC0 head bit4 = 1, D1_almost_full = 1, VC1 head bit4 = 0 -> VC1 popped every cycle, VC0_pop = 0; dropping D1_almost_full resumes VC0 on the next cycle.
- enable drops the cycle after a VC0 pop -> valid_out = 1, vc_sel = 0 for that cycle, then no pops and state_out = 00.
- reset_L pulsed low with cnt = 2 mid-burst -> outputs 0 asynchronously; after release, VC0 receives 4 grants before VC1.
